// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the ID stage and pipe_hazard_unit: the ID request and flush in,
// and the stall, forward-select and scoreboard status out.
interface pipe_hazard_unit_if #(
    parameter int RA_W  = 3,
    parameter int DEPTH = 4,
    parameter int SEL_W = 2
);
    // Accept rule: ID enters EX on a posedge with id_valid & !stall & !flush.
    // While stall is high, ID keeps presenting the same instruction.
    logic             id_valid;
    logic [RA_W-1:0]  id_ra;
    logic [RA_W-1:0]  id_rb;
    logic             id_ra_used;
    logic             id_rb_used;
    logic             id_we;
    logic [RA_W-1:0]  id_rd;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [DEPTH-1:0] stage_valid;
    logic             wb_we;
    logic [RA_W-1:0]  wb_rd;
    logic [15:0]      stall_cnt;
    logic [15:0]      flush_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_we, id_rd,
               id_is_load, flush,
        input  stall, fwd_a, fwd_b, stage_valid, wb_we, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_we, id_rd,
               id_is_load, flush,
        output stall, fwd_a, fwd_b, stage_valid, wb_we, wb_rd, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: shift-register scoreboard of in-flight destinations, load-use stall,
// EX forward selects and flush bubbles. Define R0_ZERO_EN to make r0 constant zero.
module pipe_hazard_unit #(
    parameter int RA_W       = 3,
    parameter int DEPTH      = 4,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    parameter int SEL_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_unit_if.slave hz
);
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0]           we_q, we_d;
    logic [DEPTH-1:0]           ld_q, ld_d;
    logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
    logic [RA_W-1:0]            ra_q, ra_d, rb_q, rb_d;
    logic                       ra_used_q, ra_used_d, rb_used_q, rb_used_d;
    logic [15:0]                stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [DEPTH-1:0]           live;
    logic [SEL_W-1:0]           fwd_a, fwd_b;
    logic                       early_a, early_b;
    logic                       hit_a, hit_b;
    logic                       stall;

    // An entry can be matched only if it is valid and writes; r0 is excluded when hardwired.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
`ifdef R0_ZERO_EN
            live[k] = valid_q[k] & we_q[k] & (rd_q[k] != '0);
`else
            live[k] = valid_q[k] & we_q[k];
`endif
        end
    end

    // Scan oldest to youngest so the youngest producer is the last one written.
    always_comb begin
        fwd_a   = '0;
        fwd_b   = '0;
        early_a = 1'b0;
        early_b = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (valid_q[0] && ra_used_q && live[k] && (rd_q[k] == ra_q)) begin
                fwd_a   = SEL_W'(k);
                early_a = ld_q[k] && (k < LOAD_STAGE);
            end
            if (valid_q[0] && rb_used_q && live[k] && (rd_q[k] == rb_q)) begin
                fwd_b   = SEL_W'(k);
                early_b = ld_q[k] && (k < LOAD_STAGE);
            end
        end
    end

    // Looks one cycle ahead: a producer now at stage j sits at j+1 when ID reaches EX.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (live[j] && (rd_q[j] == hz.id_ra)) hit_a = ld_q[j] && (j + 1 < LOAD_STAGE);
            if (live[j] && (rd_q[j] == hz.id_rb)) hit_b = ld_q[j] && (j + 1 < LOAD_STAGE);
        end
        stall = hz.id_valid && !hz.flush &&
                ((hz.id_ra_used && hit_a) || (hz.id_rb_used && hit_b));
    end

    always_comb begin
        valid_d   = '0;
        we_d      = '0;
        ld_d      = '0;
        rd_d      = '0;
        ra_d      = '0;
        rb_d      = '0;
        ra_used_d = 1'b0;
        rb_used_d = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (!(hz.flush && (i < BR_STAGE))) begin
                valid_d[i] = valid_q[i-1];
                we_d[i]    = we_q[i-1];
                ld_d[i]    = ld_q[i-1];
                rd_d[i]    = rd_q[i-1];
            end
        end
        if (hz.id_valid && !stall && !hz.flush) begin
            valid_d[0] = 1'b1;
            we_d[0]    = hz.id_we;
            ld_d[0]    = hz.id_is_load;
            rd_d[0]    = hz.id_rd;
            ra_d       = hz.id_ra;
            rb_d       = hz.id_rb;
            ra_used_d  = hz.id_ra_used;
            rb_used_d  = hz.id_rb_used;
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (hz.flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            ra_used_q   <= 1'b0;
            rb_used_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            ra_used_q   <= ra_used_d;
            rb_used_q   <= rb_used_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall       = stall;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.stage_valid = valid_q;
    assign hz.wb_we       = live[DEPTH-1];
    assign hz.wb_rd       = rd_q[DEPTH-1];
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    // The stall must keep any load that is not yet forwardable out of the EX selects.
    a_no_early_load: assert property (@(posedge clk) disable iff (!rst_n) !(early_a || early_b));

endmodule
